// File: rtl/pc_pkg.sv
// Shared types for the program counter with return-address stack:
// the per-cycle operation code and its priority decode.
package pc_pkg;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_LOAD,
        PC_CALL,
        PC_RET,
        PC_STALL
    } pc_op_e;

    // Exactly one action per cycle: stall > ret > call > load > inc > hold.
    function automatic pc_op_e pc_decode(
        input logic stall,
        input logic ret,
        input logic call,
        input logic load,
        input logic inc
    );
        if (stall)     return PC_STALL;
        else if (ret)  return PC_RET;
        else if (call) return PC_CALL;
        else if (load) return PC_LOAD;
        else if (inc)  return PC_INC;
        else           return PC_HOLD;
    endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// LIFO of return addresses. Owns the stack pointer; a push while full or a
// pop while empty leaves the pointer and the contents unchanged.
module pc_ret_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] sp,
    output logic                       full,
    output logic                       empty
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [SPW-1:0]   sp_q;
    logic [SPW-1:0]   sp_d;
    logic [SPW-1:0]   sp_m1;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic             do_push;
    logic             do_pop;

    assign empty   = (sp_q == '0);
    assign full    = (sp_q == SPW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && !pop && !full;

    assign sp_m1  = sp_q - SPW'(1);
    assign wr_idx = sp_q[AW-1:0];
    assign rd_idx = sp_m1[AW-1:0];

    // Top-of-stack is read combinationally so a ret can use it on the same edge.
    assign rdata = empty ? '0 : mem[rd_idx];
    assign sp    = sp_q;

    always_comb begin
        sp_d = sp_q;
        if (do_pop)
            sp_d = sp_m1;
        else if (do_push)
            sp_d = sp_q + SPW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sp_q <= '0;
        else
            sp_q <= sp_d;
    end

    // Storage is deliberately not reset; entries at or above sp are never read.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_idx] <= wdata;
    end

endmodule

// File: rtl/pc_call_stack.sv
// Fetch-path program counter with load/increment, subroutine call/return
// through a hardware return stack, fetch stall and sticky stack-error flags.
module pc_call_stack
    import pc_pkg::*;
#(
    parameter int                WIDTH     = 16,
    parameter int                DEPTH     = 8,
    parameter logic [WIDTH-1:0]  RESET_VEC = '0
) (
    input  logic                       clock,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           in,
    input  logic                       load,
    input  logic                       inc,
    input  logic                       call,
    input  logic                       ret,
    input  logic                       stall,
    output logic [WIDTH-1:0]           out,
    output logic [$clog2(DEPTH+1)-1:0] sp,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    pc_op_e           op;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             overflow_q;
    logic             overflow_d;
    logic             underflow_q;
    logic             underflow_d;
    logic [WIDTH-1:0] ret_addr;
    logic [WIDTH-1:0] out_plus1;
    logic             stk_full;
    logic             stk_empty;

    assign op        = pc_decode(stall, ret, call, load, inc);
    assign out_plus1 = out_q + WIDTH'(1);

    pc_ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk   (clock),
        .rst_n (rst_n),
        .push  (op == PC_CALL),
        .pop   (op == PC_RET),
        .wdata (out_plus1),
        .rdata (ret_addr),
        .sp    (sp),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_comb begin
        out_d       = out_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        unique case (op)
            PC_RET: begin
                if (stk_empty)
                    underflow_d = 1'b1;
                else
                    out_d = ret_addr;
            end
            // The jump is taken even when the push has to be dropped.
            PC_CALL: begin
                out_d = in;
                if (stk_full)
                    overflow_d = 1'b1;
            end
            PC_LOAD: out_d = in;
            PC_INC:  out_d = out_plus1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= RESET_VEC;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign out       = out_q;
    assign empty     = stk_empty;
    assign full      = stk_full;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_pc_call_stack.sv
// Directed bench for pc_call_stack (WIDTH=16, DEPTH=8, RESET_VEC=0).
module tb_pc_call_stack;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_s  = '0;
    logic        load_s = 1'b0, inc_s = 1'b0, call_s = 1'b0, ret_s = 1'b0, stall_s = 1'b0;
    logic [15:0] out_s;
    logic [3:0]  sp_s;
    logic        empty_s, full_s, ovf_s, unf_s;

    int n_cmp = 0;
    int n_err = 0;

    pc_call_stack #(.WIDTH(16), .DEPTH(8), .RESET_VEC(16'h0000)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .in        (in_s),
        .load      (load_s),
        .inc       (inc_s),
        .call      (call_s),
        .ret       (ret_s),
        .stall     (stall_s),
        .out       (out_s),
        .sp        (sp_s),
        .empty     (empty_s),
        .full      (full_s),
        .overflow  (ovf_s),
        .underflow (unf_s)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // One cycle: apply controls just after an edge, sample 1 time unit after the next edge.
    task automatic cyc(input logic s, input logic r, input logic c,
                       input logic l, input logic i, input logic [15:0] a);
        stall_s = s; ret_s = r; call_s = c; load_s = l; inc_s = i; in_s = a;
        @(posedge clock);
        #1;
        stall_s = 0; ret_s = 0; call_s = 0; load_s = 0; inc_s = 0; in_s = '0;
    endtask

    logic [15:0] pushed [8];
    logic [15:0] pc_exp;

    initial begin
        // Reset state
        #3;
        check("rst_out", out_s, 0);
        check("rst_sp", sp_s, 0);
        check("rst_empty", empty_s, 1);
        check("rst_full", full_s, 0);
        check("rst_ovf", ovf_s, 0);
        check("rst_unf", unf_s, 0);
        @(posedge clock); #1;
        rst_n = 1'b1;

        // inc x3
        cyc(0,0,0,0,1,0); check("inc1", out_s, 16'h0001);
        cyc(0,0,0,0,1,0); check("inc2", out_s, 16'h0002);
        cyc(0,0,0,0,1,0); check("inc3", out_s, 16'h0003);
        cyc(0,0,1,0,0,16'h0100);
        check("pre_rst_out", out_s, 16'h0100);
        check("pre_rst_sp", sp_s, 1);

        // Asynchronous reset mid-stream, with an inc pending
        inc_s = 1'b1;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", out_s, 0);
        check("async_rst_sp", sp_s, 0);
        check("async_rst_empty", empty_s, 1);
        @(posedge clock); #1;
        check("rst_hold_out", out_s, 0);
        inc_s = 1'b0;
        rst_n = 1'b1;

        // Simple call / return
        cyc(0,0,0,1,0,16'h0010); check("load10", out_s, 16'h0010);
        cyc(0,0,1,0,0,16'h0200); check("call_out", out_s, 16'h0200);
        check("call_sp", sp_s, 1);
        cyc(0,0,0,0,1,0);
        cyc(0,0,0,0,1,0); check("sub_inc", out_s, 16'h0202);
        cyc(0,1,0,0,0,0); check("ret_out", out_s, 16'h0011);
        check("ret_sp", sp_s, 0);
        check("ret_empty", empty_s, 1);

        // Nested calls to full depth
        pc_exp = 16'h0011;
        for (int k = 0; k < 8; k++) begin
            pushed[k] = pc_exp + 16'h0001;
            pc_exp = 16'h1000 + 16'(k * 16);
            cyc(0,0,1,0,0,pc_exp);
        end
        check("nest_out", out_s, 16'h1070);
        check("nest_sp", sp_s, 8);
        check("nest_full", full_s, 1);
        check("nest_ovf", ovf_s, 0);
        cyc(0,0,1,0,0,16'h0ABC);
        check("ovf_out", out_s, 16'h0ABC);
        check("ovf_sp", sp_s, 8);
        check("ovf_flag", ovf_s, 1);
        for (int k = 7; k >= 0; k--) begin
            cyc(0,1,0,0,0,0);
            check($sformatf("lifo_%0d", k), out_s, pushed[k]);
        end
        check("lifo_first", pushed[0], 16'h0012);
        check("lifo_sp", sp_s, 0);
        check("lifo_empty", empty_s, 1);

        // Underflow
        cyc(0,0,0,1,0,16'h0042);
        cyc(0,1,0,0,0,0);
        check("unf_out", out_s, 16'h0042);
        check("unf_sp", sp_s, 0);
        check("unf_flag", unf_s, 1);
        cyc(0,0,1,0,0,16'h0300);
        check("unf_sticky_out", out_s, 16'h0300);
        check("unf_sticky", unf_s, 1);
        cyc(0,1,0,0,0,0);
        check("unf_ret", out_s, 16'h0043);
        check("ovf_sticky", ovf_s, 1);

        // Wrap-around
        cyc(0,0,0,1,0,16'hFFFF);
        cyc(0,0,0,0,1,0); check("wrap_inc", out_s, 16'h0000);
        cyc(0,0,0,1,0,16'hFFFF);
        cyc(0,0,1,0,0,16'h0500);
        check("wrap_call", out_s, 16'h0500);
        check("wrap_call_sp", sp_s, 1);
        cyc(0,1,0,0,0,0);
        check("wrap_ret", out_s, 16'h0000);
        check("wrap_ret_sp", sp_s, 0);

        // Stall and call+ret priority
        cyc(0,0,1,0,0,16'h0600);
        cyc(0,0,1,0,0,16'h0700);
        check("pre_stall_sp", sp_s, 2);
        cyc(1,0,1,1,1,16'h1234);
        check("stall_out", out_s, 16'h0700);
        check("stall_sp", sp_s, 2);
        check("stall_ovf", ovf_s, 1);
        check("stall_unf", unf_s, 1);
        cyc(1,1,0,0,0,0);
        check("stall_ret_sp", sp_s, 2);
        check("stall_ret_out", out_s, 16'h0700);
        cyc(0,1,1,1,1,16'h2222);
        check("callret_out", out_s, 16'h0601);
        check("callret_sp", sp_s, 1);
        cyc(0,1,0,0,0,0);
        check("final_ret", out_s, 16'h0001);
        check("final_empty", empty_s, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
